ex_muldiv_unit: RTL

// - EX-stage multi-cycle multiply/divide unit owning the HI/LO registers.
// - Consumes the EX_start / EX_md_control fields leaving the ID/EX register, plus forwarded rs/rt operands.
// - Drives busy back as the stall2 input of the ID/EX register; the pipeline holds while busy is high.

---
 rtl/ex_muldiv_unit_if.sv | 12 +
 rtl/ex_muldiv_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: EX-stage mul/div handshake (start, md_control, operands in; hi, lo, busy out)
interface ex_muldiv_unit_if;
  logic        start;
  logic [2:0]  md_control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  modport master(output start, md_control, op_a, op_b, input hi, lo, busy);
  modport slave(input start, md_control, op_a, op_b, output hi, lo, busy);
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO; clock, reset, md (slave), optional div_by_zero when MD_DIVZERO_FLAG_EN
module ex_muldiv_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_ITERS  = 32
) (
  input  logic clock,
  input  logic reset,
`ifdef MD_DIVZERO_FLAG_EN
  output logic div_by_zero,
`endif
  ex_muldiv_unit_if.slave md
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic        sgn_q, sgn_d, neg_q, neg_d, sa_q, sa_d, dz_q, dz_d, busy_q;
  logic [63:0] prod;
  logic [32:0] rem_sh;
  logic        ge, sdiv;
  assign prod   = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
  assign rem_sh = {rem_q, a_q[31]};
  assign ge     = rem_sh >= {1'b0, b_q};
  assign sdiv   = md.md_control == 3'd3;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
  assign md.busy = busy_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (md.start) begin
        if (md.md_control == 3'd1 || md.md_control == 3'd2) begin
          a_d     = md.op_a;
          b_d     = md.op_b;
          sgn_d   = md.md_control == 3'd1;
          cnt_d   = 5'(MUL_CYCLES - 1);
          state_d = MUL;
        end else if (md.md_control == 3'd3 || md.md_control == 3'd4) begin
          dz_d    = md.op_b == '0;
          neg_d   = sdiv & (md.op_a[31] ^ md.op_b[31]);
          sa_d    = sdiv & md.op_a[31];
          a_d     = (sdiv && md.op_a[31] && md.op_b != '0) ? -md.op_a : md.op_a;
          b_d     = (sdiv && md.op_b[31]) ? -md.op_b : md.op_b;
          rem_d   = '0;
          cnt_d   = 5'(DIV_ITERS - 1);
          state_d = (md.op_b == '0) ? FIX : DIV;
        end else if (md.md_control == 3'd5) begin
          hi_d = md.op_a;
        end else if (md.md_control == 3'd6) begin
          lo_d = md.op_a;
        end
      end
      MUL: begin
        cnt_d = cnt_q - 5'(cnt_q != '0);
        if (cnt_q == '0) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = IDLE;
        end
      end
      DIV: begin
        rem_d   = ge ? 32'(rem_sh - {1'b0, b_q}) : rem_sh[31:0];
        a_d     = {a_q[30:0], ge};
        cnt_d   = cnt_q - 5'(cnt_q != '0);
        state_d = (cnt_q == '0) ? FIX : DIV;
      end
      default: begin
        hi_d    = dz_q ? a_q : (sa_q ? -rem_q : rem_q);
        lo_d    = dz_q ? 32'hFFFF_FFFF : (neg_q ? -a_q : a_q);
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= state_d != IDLE;
    end
  end
`ifdef MD_DIVZERO_FLAG_EN
  logic dzf_q, dzf_d;
  always_comb begin
    dzf_d = (state_q == FIX && dz_q) || (dzf_q && !(state_q == IDLE && md.start));
  end
  always_ff @(posedge clock) begin
    if (reset) dzf_q <= 1'b0;
    else dzf_q <= dzf_d;
  end
  assign div_by_zero = dzf_q;
`endif
endmodule
